// File: rtl/me_best_mv_tracker_if.sv
// SAD-stream interface between the ME array/controller and the best-MV tracker.
// The master drives start/valid/sad; the slave (tracker) returns status and the result.
interface me_best_mv_tracker_if #(
  parameter int SAD_W = 16,
  parameter int MV_W  = 6
);
  logic              start;
  logic              valid;
  logic [SAD_W-1:0]  sad;
  logic              busy;
  logic              done;
  logic [MV_W-1:0]   mv_x;
  logic [MV_W-1:0]   mv_y;
  logic [SAD_W-1:0]  min_sad;

  modport master (
    output start, valid, sad,
    input  busy, done, mv_x, mv_y, min_sad
  );

  modport slave (
    input  start, valid, sad,
    output busy, done, mv_x, mv_y, min_sad
  );
endinterface

// File: rtl/me_best_mv_tracker.sv
// Tracks the minimum-SAD candidate of a serpentine-scanned ME search and reports its signed MV.
// Optional feature: define ME_ZERO_BIAS_EN to credit the (0,0) candidate with ZERO_BIAS.
module me_best_mv_tracker #(
  parameter int MACRO_DIM  = 16,
  parameter int SEARCH_DIM = 48,
  parameter int SAD_W      = 16,
  parameter int ZERO_BIAS  = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  me_best_mv_tracker_if.slave   bus
);

  localparam int N     = SEARCH_DIM - MACRO_DIM;
  localparam int IDX_W = $clog2(N);
  localparam int MV_W  = IDX_W + 1;
  localparam int CNT_W = 2 * IDX_W;

`ifdef ME_ZERO_BIAS_EN
  localparam bit BIAS_EN = 1'b1;
`else
  localparam bit BIAS_EN = 1'b0;
`endif
  localparam logic [SAD_W-1:0] BIAS = SAD_W'(ZERO_BIAS);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} state_t;
  // Down means the row index increments (even columns).
  typedef enum logic {DIR_DOWN, DIR_UP} dir_t;

  state_t             r_state, w_next;
  dir_t               r_dir;
  logic [IDX_W-1:0]   r_col, r_row;
  logic [CNT_W-1:0]   r_cnt;
  logic [SAD_W-1:0]   r_min_sad;
  logic [MV_W-1:0]    r_mv_x, r_mv_y;

  logic               w_clear, w_accept, w_last, w_col_end, w_center;
  logic [SAD_W-1:0]   w_sad_eff;
  logic [MV_W-1:0]    w_mv_x_cand, w_mv_y_cand;

  // Any start (re)opens a search: from IDLE, from DONE, or as an abort while collecting.
  assign w_clear     = bus.start;
  assign w_accept    = (r_state == S_COLLECT) && bus.valid && !bus.start;
  assign w_last      = (r_cnt == CNT_W'(N * N - 1));
  assign w_col_end   = (r_dir == DIR_DOWN) ? (r_row == IDX_W'(N - 1)) : (r_row == '0);
  assign w_center    = (r_col == IDX_W'(N / 2)) && (r_row == IDX_W'(N / 2));
  assign w_mv_x_cand = {1'b0, r_col} - MV_W'(N / 2);
  assign w_mv_y_cand = {1'b0, r_row} - MV_W'(N / 2);

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_sad_eff = bus.sad;
    if (BIAS_EN && w_center)
      w_sad_eff = (bus.sad > BIAS) ? (bus.sad - BIAS) : '0;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    if (bus.start) w_next = S_COLLECT;
      S_COLLECT: if (bus.start) w_next = S_COLLECT;
                 else if (bus.valid && w_last) w_next = S_DONE;
      S_DONE:    w_next = bus.start ? S_COLLECT : S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col     <= '0;
      r_row     <= '0;
      r_dir     <= DIR_DOWN;
      r_cnt     <= '0;
      r_min_sad <= '1;
      r_mv_x    <= '0;
      r_mv_y    <= '0;
    end else if (w_clear) begin
      r_col     <= '0;
      r_row     <= '0;
      r_dir     <= DIR_DOWN;
      r_cnt     <= '0;
      r_min_sad <= '1;
      r_mv_x    <= '0;
      r_mv_y    <= '0;
    end else if (w_accept) begin
      // Strict less-than: on a tie the earlier candidate is kept.
      if (w_sad_eff < r_min_sad) begin
        r_min_sad <= w_sad_eff;
        r_mv_x    <= w_mv_x_cand;
        r_mv_y    <= w_mv_y_cand;
      end
      r_cnt <= r_cnt + 1'b1;
      if (w_col_end) begin
        r_col <= r_col + 1'b1;
        r_dir <= (r_dir == DIR_DOWN) ? DIR_UP : DIR_DOWN;
      end else if (r_dir == DIR_DOWN) begin
        r_row <= r_row + 1'b1;
      end else begin
        r_row <= r_row - 1'b1;
      end
    end
  end

  assign bus.busy    = (r_state == S_COLLECT);
  assign bus.done    = (r_state == S_DONE);
  assign bus.mv_x    = r_mv_x;
  assign bus.mv_y    = r_mv_y;
  assign bus.min_sad = r_min_sad;

endmodule

// File: tb/tb_me_best_mv_tracker.sv
// Randomized self-checking bench for me_best_mv_tracker against a scan-order reference model.
// Honors ME_ZERO_BIAS_EN the same way the design does.
module tb_me_best_mv_tracker;

  localparam int N      = 32;
  localparam int NN     = N * N;
  localparam int SAD_W  = 16;
  localparam int MV_W   = 6;
  localparam int BIAS   = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int unsigned sads [NN];
  int   exp_x, exp_y, exp_sad;

  me_best_mv_tracker_if #(.SAD_W(SAD_W), .MV_W(MV_W)) bus ();

  me_best_mv_tracker #(
    .MACRO_DIM(16), .SEARCH_DIM(48), .SAD_W(SAD_W), .ZERO_BIAS(BIAS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference: k-th valid of a search sits at column k/N; rows run down on even and up on odd columns.
  task automatic model();
    int best = 65536;
    exp_x = 0; exp_y = 0;
    for (int k = 0; k < NN; k++) begin
      int col = k / N;
      int row = (col % 2 == 0) ? (k % N) : (N - 1 - (k % N));
      int eff = int'(sads[k]);
`ifdef ME_ZERO_BIAS_EN
      if (col == N / 2 && row == N / 2) eff = (eff > BIAS) ? eff - BIAS : 0;
`endif
      if (eff < best) begin
        best  = eff;
        exp_x = col - N / 2;
        exp_y = row - N / 2;
      end
    end
    exp_sad = best;
  endtask

  // All tasks start and end at #1 after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pulse(input string tag, input bit with_valid);
    bus.start = 1'b1; bus.valid = with_valid; bus.sad = '0;
    tick();
    bus.start = 1'b0; bus.valid = 1'b0;
    n_tests++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s start: busy=%b done=%b, required busy=1 done=0", tag, bus.busy, bus.done);
    end
  endtask

  // Feeds the first n entries of sads[], with random idle gaps when requested.
  task automatic feed(input string tag, input int n, input bit gaps);
    int early = 0;
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(3) == 0) begin
        bus.valid = 1'b0; bus.sad = SAD_W'($urandom);
        tick();
        if (bus.done !== 1'b0) early++;
      end
      bus.valid = 1'b1; bus.sad = SAD_W'(sads[i]);
      tick();
      if (i < n - 1 && bus.done !== 1'b0) early++;
    end
    bus.valid = 1'b0;
    n_tests++;
    if (early != 0) begin
      n_fail++;
      $display("FAIL %s early_done: %0d cycles with done=1, required 0", tag, early);
    end
  endtask

  task automatic check_result(input string tag);
    model();
    n_tests++;
    if (bus.done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s done_latency: done=%b one cycle after last valid, required 1", tag, bus.done);
    end
    n_tests++;
    if ($signed(bus.mv_x) !== MV_W'(exp_x) || $signed(bus.mv_y) !== MV_W'(exp_y)) begin
      n_fail++;
      $display("FAIL %s mv: got (%0d,%0d), required (%0d,%0d)", tag,
               $signed(bus.mv_x), $signed(bus.mv_y), exp_x, exp_y);
    end
    n_tests++;
    if (bus.min_sad !== SAD_W'(exp_sad)) begin
      n_fail++;
      $display("FAIL %s min_sad: got %0d, required %0d", tag, bus.min_sad, exp_sad);
    end
  endtask

  task automatic check_hold(input string tag);
    bus.valid = 1'b1; bus.sad = '0;
    tick();
    tick();
    bus.valid = 1'b0;
    n_tests++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.min_sad !== SAD_W'(exp_sad) ||
        $signed(bus.mv_x) !== MV_W'(exp_x) || $signed(bus.mv_y) !== MV_W'(exp_y)) begin
      n_fail++;
      $display("FAIL %s hold: done=%b busy=%b mv=(%0d,%0d) min_sad=%0d, required 0 0 (%0d,%0d) %0d",
               tag, bus.done, bus.busy, $signed(bus.mv_x), $signed(bus.mv_y), bus.min_sad,
               exp_x, exp_y, exp_sad);
    end
  endtask

  task automatic fill(input int unsigned v);
    for (int k = 0; k < NN; k++) sads[k] = v;
  endtask

  task automatic full_search(input string tag, input bit gaps);
    start_pulse(tag, 1'b0);
    feed(tag, NN, gaps);
    check_result(tag);
    check_hold(tag);
  endtask

  task automatic test_reset();
    int bad = 0;
    bus.start = 1'b0; bus.valid = 1'b0; bus.sad = '0;
    rst_n = 1'b0;
    repeat (3) tick();
    n_tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.mv_x !== '0 || bus.mv_y !== '0 || bus.min_sad !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL reset: busy=%b done=%b mv=(%0d,%0d) min_sad=%h, required 0 0 (0,0) ffff",
               bus.busy, bus.done, $signed(bus.mv_x), $signed(bus.mv_y), bus.min_sad);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 100; c++) begin
      bus.valid = 1'($urandom); bus.sad = SAD_W'($urandom);
      tick();
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) bad++;
    end
    bus.valid = 1'b0;
    n_tests++;
    if (bad != 0 || bus.mv_x !== '0 || bus.mv_y !== '0 || bus.min_sad !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL idle_valid: %0d busy/done cycles, mv=(%0d,%0d) min_sad=%h, required 0 (0,0) ffff",
               bad, $signed(bus.mv_x), $signed(bus.mv_y), bus.min_sad);
    end
  endtask

  task automatic test_single_min();
    fill(1000); sads[6] = 5;
    full_search("single_min", 1'b0);
  endtask

  task automatic test_serpentine();
    fill(1000); sads[32] = 7;
    full_search("serpentine", 1'b1);
  endtask

  task automatic test_tie();
    fill(300); sads[64] = 200; sads[5 * N + (N - 1 - 9)] = 200;
    full_search("tie", 1'b0);
  endtask

  task automatic test_abort();
    fill(1000); sads[10] = 3;
    start_pulse("abort_first", 1'b0);
    feed("abort_first", 400, 1'b1);
    fill(500);
    start_pulse("abort_restart", 1'b0);
    feed("abort_restart", NN, 1'b0);
    check_result("abort_restart");
    check_hold("abort_restart");
  endtask

  task automatic test_bias();
    fill(100); sads[(N / 2) * N + N / 2] = 150;
    full_search("bias", 1'b0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < NN; k++) sads[k] = $urandom_range(65535);
      full_search("random", 1'b1);
    end
  endtask

  task automatic test_start_valid_idle();
    fill(900); sads[0] = 800; sads[NN - 1] = 850;
    start_pulse("start_valid", 1'b1);
    feed("start_valid", NN, 1'b0);
    check_result("start_valid");
    check_hold("start_valid");
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < NN; k++) sads[k] = $urandom_range(65535);
    start_pulse("b2b_first", 1'b0);
    feed("b2b_first", NN, 1'b0);
    check_result("b2b_first");
    for (int k = 0; k < NN; k++) sads[k] = $urandom_range(1000, 65535);
    sads[700] = 17;
    start_pulse("b2b_from_done", 1'b0);
    feed("b2b_second", NN, 1'b1);
    check_result("b2b_second");
    check_hold("b2b_second");
  endtask

  task automatic test_async_reset();
    int bad = 0;
    fill(1000); sads[20] = 2;
    start_pulse("async_rst", 1'b0);
    feed("async_rst", 300, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.mv_x !== '0 || bus.mv_y !== '0 || bus.min_sad !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL async_rst: busy=%b done=%b mv=(%0d,%0d) min_sad=%h, required 0 0 (0,0) ffff",
               bus.busy, bus.done, $signed(bus.mv_x), $signed(bus.mv_y), bus.min_sad);
    end
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      bus.valid = 1'b1; bus.sad = SAD_W'($urandom);
      tick();
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) bad++;
    end
    bus.valid = 1'b0;
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL async_rst_quiet: %0d cycles with busy/done=1 after reset, required 0", bad);
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.valid = 1'b0; bus.sad = '0;
    #1;
    test_reset();
    test_single_min();
    test_serpentine();
    test_tie();
    test_abort();
    test_bias();
    test_start_valid_idle();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
